// File: rtl/mod_exp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer driving a Montgomery
// multiplier. Holds the Montgomery-domain accumulator and issues one square per
// exponent bit from the leading '1' down to bit 0, plus one multiply per '1' bit.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start; operands captured on acceptance
// SCAN    | skipping leading zeros of the exponent, one bit per cycle
// GAP     | waiting for two consecutive idle cycles so the multiplier re-arms
// ISSUE   | loading multiplier operands and raising mm_start
// ACK     | holding mm_start until the multiplier drops mm_done
// WAIT    | waiting for the product; operands held stable
// NEXT    | deciding between multiply, next square, or finish
// FIN     | one-cycle done pulse
module mod_exp_ctrl #(
    parameter int K    = 192,
    parameter int LOGK = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] base_m,
    input  logic [K-1:0] one_m,
    input  logic [K-1:0] exp,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] result,
    output logic [K-1:0] mm_x,
    output logic [K-1:0] mm_y,
    output logic         mm_start,
    input  logic [K-1:0] mm_z,
    input  logic         mm_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_GAP, S_ISSUE, S_ACK, S_WAIT, S_NEXT, S_FIN
    } state_t;

    typedef enum logic {OP_SQ, OP_MUL} op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [K-1:0]    acc_q, acc_d;
    logic [K-1:0]    base_q, base_d;
    logic [K-1:0]    e_q, e_d;
    logic [LOGK-1:0] bits_q, bits_d;
    logic [1:0]      gap_q, gap_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [K-1:0]    result_q, result_d;
    logic [K-1:0]    mm_x_q, mm_x_d;
    logic [K-1:0]    mm_y_q, mm_y_d;
    logic            mm_start_q, mm_start_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_SQ;
            acc_q      <= '0;
            base_q     <= '0;
            e_q        <= '0;
            bits_q     <= '0;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            mm_x_q     <= '0;
            mm_y_q     <= '0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            e_q        <= e_d;
            bits_q     <= bits_d;
            gap_q      <= gap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            mm_x_q     <= mm_x_d;
            mm_y_q     <= mm_y_d;
            mm_start_q <= mm_start_d;
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        base_d     = base_q;
        e_d        = e_q;
        bits_d     = bits_q;
        gap_d      = gap_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        mm_x_d     = mm_x_q;
        mm_y_d     = mm_y_q;
        mm_start_d = mm_start_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_m;
                    e_d     = exp;
                    acc_d   = one_m;
                    bits_d  = LOGK'(K);
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (e_q[K-1]) begin
                    op_d    = OP_SQ;
                    gap_d   = 2'd0;
                    state_d = S_GAP;
                end else if (bits_q == LOGK'(1)) begin
                    // zero exponent: the Montgomery one is the answer, no multiplier use
                    result_d = acc_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_FIN;
                end else begin
                    e_d    = {e_q[K-2:0], 1'b0};
                    bits_d = bits_q - LOGK'(1);
                end
            end
            S_GAP: begin
                if (!mm_done) begin
                    gap_d = 2'd0;
                end else if (gap_q == 2'd1) begin
                    gap_d   = 2'd0;
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q + 2'd1;
                end
            end
            S_ISSUE: begin
                mm_x_d     = acc_q;
                mm_y_d     = (op_q == OP_SQ) ? acc_q : base_q;
                mm_start_d = 1'b1;
                state_d    = S_ACK;
            end
            S_ACK: begin
                if (!mm_done) begin
                    mm_start_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mm_done) begin
                    acc_d   = mm_z;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (op_q == OP_SQ && e_q[K-1]) begin
                    op_d    = OP_MUL;
                    state_d = S_GAP;
                end else if (bits_q == LOGK'(1)) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_FIN;
                end else begin
                    e_d     = {e_q[K-2:0], 1'b0};
                    bits_d  = bits_q - LOGK'(1);
                    op_d    = OP_SQ;
                    state_d = S_GAP;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign mm_x     = mm_x_q;
    assign mm_y     = mm_y_q;
    assign mm_start = mm_start_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl with K=8 against a behavioural Montgomery multiplier
// (m = 241, R = 256, latency 12). Expected results come from plain modular
// exponentiation; expected operand pairs come from the square-and-multiply rule.
module tb_mod_exp_ctrl;
    localparam int K     = 8;
    localparam int LOGK  = 4;
    localparam int M     = 241;
    localparam int RINV  = 225;   // 256^-1 mod 241
    localparam int ONE_M = 15;    // 256 mod 241
    localparam int LAT   = 12;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [K-1:0] base_m = '0;
    logic [K-1:0] one_m = '0;
    logic [K-1:0] exp_v = '0;
    logic         busy, done, mm_start;
    logic [K-1:0] result, mm_x, mm_y;
    logic [K-1:0] mm_z_r = '0;
    logic         mm_done_r = 1'b1;

    mod_exp_ctrl #(.K(K), .LOGK(LOGK)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_m(base_m), .one_m(one_m), .exp(exp_v),
        .busy(busy), .done(done), .result(result),
        .mm_x(mm_x), .mm_y(mm_y), .mm_start(mm_start),
        .mm_z(mm_z_r), .mm_done(mm_done_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_fail = 0;

    task automatic check(string name, int act, int expv);
        n_vec++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int mont(int x, int y);
        return (x * y * RINV) % M;
    endfunction

    // Behavioural multiplier: re-arms only after seeing start low while idle
    int   mcnt = 0;
    bit   mbusy = 0;
    bit   marmed = 1;
    int   mx = 0, my = 0;
    int   done_rise_cyc = 0;
    always @(posedge clk) begin
        if (reset) begin
            mbusy         <= 0;
            mm_done_r     <= 1'b1;
            marmed        <= 1;
            mcnt          <= 0;
            done_rise_cyc <= cyc;
        end else if (mbusy) begin
            if (mcnt == 1) begin
                mbusy         <= 0;
                mm_done_r     <= 1'b1;
                mm_z_r        <= K'(mont(mx, my));
                done_rise_cyc <= cyc;
            end else begin
                mcnt <= mcnt - 1;
            end
        end else if (!mm_start) begin
            marmed <= 1;
        end else if (marmed) begin
            mbusy     <= 1;
            mm_done_r <= 1'b0;
            mx        <= int'(mm_x);
            my        <= int'(mm_y);
            mcnt      <= LAT;
            marmed    <= 0;
        end
    end

    // Scoreboard queues
    typedef struct {
        int x;
        int y;
    } exp_op_t;
    exp_op_t op_q[$];
    int      res_q[$];
    int      ops_seen = 0;
    int      runs_done = 0;
    int      done_cyc = 0;
    logic    prev_start = 1'b0;

    // Monitor: checks each issued operation and each finished result
    always @(negedge clk) begin
        if (!reset && mm_start && !prev_start) begin
            exp_op_t o;
            ops_seen++;
            // done rising must be followed by WAIT sample, NEXT, two gap cycles and ISSUE
            check("op_gap", (cyc - done_rise_cyc >= 5) ? 1 : 0, 1);
            if (op_q.size() == 0) begin
                check("unexpected_op", 1, 0);
            end else begin
                o = op_q.pop_front();
                check("op_x", int'(mm_x), o.x);
                check("op_y", int'(mm_y), o.y);
            end
        end
        prev_start = mm_start;
        if (done) begin
            runs_done++;
            done_cyc = cyc;
            if (res_q.size() == 0) check("unexpected_done", 1, 0);
            else check("result", int'(result), res_q.pop_front());
        end
    end

    int start_cyc = 0;

    task automatic launch(int b, int e, output int n_ops);
        int bplain, r, acc, msb;
        @(negedge clk);
        base_m    = K'(b);
        exp_v     = K'(e);
        one_m     = K'(ONE_M);
        start     = 1'b1;
        start_cyc = cyc;
        bplain = (b * RINV) % M;
        r = ONE_M;
        for (int i = 0; i < e; i++) r = (r * bplain) % M;
        res_q.push_back(r);
        msb = -1;
        for (int i = K - 1; i >= 0; i--) if (e[i] && msb < 0) msb = i;
        acc = ONE_M;
        n_ops = 0;
        for (int i = msb; i >= 0; i--) begin
            op_q.push_back('{acc, acc});
            acc = mont(acc, acc);
            n_ops++;
            if (e[i]) begin
                op_q.push_back('{acc, b});
                acc = mont(acc, b);
                n_ops++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        int n0 = runs_done;
        int c = 0;
        while (runs_done == n0 && c < 1500) begin
            @(negedge clk);
            c++;
        end
        if (runs_done == n0) check("done_timeout", 0, 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
    endtask

    task automatic run(int b, int e);
        int n_ops, ops0;
        ops0 = ops_seen;
        launch(b, e, n_ops);
        wait_done();
        check("op_count", ops_seen - ops0, n_ops);
        check("ops_left", op_q.size(), 0);
    endtask

    initial begin
        int n_ops, ops0, c, b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", int'(result), 0);
        check("rst_mm_x", int'(mm_x), 0);
        check("rst_mm_y", int'(mm_y), 0);
        check("rst_mm_start", mm_start, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // exp = 0: no multiplier use, quick finish with the Montgomery one
        ops0 = ops_seen;
        launch(8'h5A, 0, n_ops);
        wait_done();
        check("exp0_ops", ops_seen - ops0, 0);
        check("exp0_latency_ok", (done_cyc - start_cyc <= K + 3) ? 1 : 0, 1);
        check("exp0_result", int'(result), 8'h0F);

        // exp = 1: square of one then one multiply
        run(8'h37, 1);
        check("exp1_result", int'(result), 8'h37);

        // exp = 11: SQ,MUL,SQ,SQ,MUL,SQ,MUL
        run(8'h9C, 8'b0000_1011);
        run($urandom_range(0, M - 1), 8'hFF);
        run($urandom_range(0, M - 1), 8'h80);

        for (int i = 0; i < 8; i++) run($urandom_range(0, M - 1), $urandom_range(0, 255));

        // start held while busy must be ignored
        b0 = $urandom_range(1, M - 1);
        ops0 = ops_seen;
        launch(b0, 8'hD7, n_ops);
        repeat (20) @(negedge clk);
        base_m = K'(M - 1 - b0);
        exp_v  = 8'h03;
        one_m  = 8'h22;
        start  = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done();
        check("busy_start_op_count", ops_seen - ops0, n_ops);
        check("busy_start_ops_left", op_q.size(), 0);

        // reset during the third operation's wait
        ops0 = ops_seen;
        launch($urandom_range(0, M - 1), 8'hB5, n_ops);
        c = 0;
        while (ops_seen < ops0 + 3 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("third_op_reached", (ops_seen >= ops0 + 3) ? 1 : 0, 1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_mm_start", mm_start, 0);
        check("midrst_result", int'(result), 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        res_q.delete();
        op_q.delete();
        repeat (2) @(negedge clk);
        run(8'h6B, 1);
        check("post_rst_result", int'(result), 8'h6B);
        run($urandom_range(0, M - 1), $urandom_range(1, 255));

        repeat (5) @(negedge clk);
        check("final_res_q_empty", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
